// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer for the execute stage.
// Multiply: the full 64-bit product is registered on the start cycle and then
// held for MUL_LAT cycles. Divide: radix-2 restoring, one quotient bit per
// cycle on magnitudes, with the signs applied on the final step.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        start;
  logic        is_div, is_uns;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] shifted, diff;
  logic        take;
  logic [31:0] rem_nx, quot_nx;

  // Operand decode, product and one restoring-divide step.
  always_comb begin
    start   = (state_q == StIdle) && valid_i && !flush_i;
    is_div  = op_i[1];
    is_uns  = op_i[0];
    a_neg   = !is_uns && a_i[31];
    b_neg   = !is_uns && b_i[31];
    a_abs   = a_neg ? (32'd0 - a_i) : a_i;
    b_abs   = b_neg ? (32'd0 - b_i) : b_i;
    // Low 64 bits of the product of 64-bit extended operands are exact for
    // both signed and unsigned forms.
    mul_a   = {{32{a_neg}}, a_i};
    mul_b   = {{32{b_neg}}, b_i};
    prod    = mul_a * mul_b;
    shifted = {rem_q, quot_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    take    = !diff[32];
    rem_nx  = take ? diff[31:0] : shifted[31:0];
    quot_nx = {quot_q[30:0], take};
  end

  // Next-state and datapath register updates; flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (!is_div) begin
            prod_d  = prod;
            cnt_d   = 5'(MUL_LAT - 1);
            state_d = StMul;
          end else if (b_i == 32'd0) begin
            hi_d    = a_i;
            lo_d    = 32'hFFFF_FFFF;
            state_d = StDone;
          end else begin
            quot_d  = a_abs;
            dvs_d   = b_abs;
            rem_d   = 32'd0;
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            cnt_d   = 5'd31;
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          state_d = StDone;
        end
      end
      StDiv: begin
        rem_d  = rem_nx;
        quot_d = quot_nx;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          lo_d    = neg_q_q ? (32'd0 - quot_nx) : quot_nx;
          hi_d    = neg_r_q ? (32'd0 - rem_nx) : rem_nx;
          state_d = StDone;
        end
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      prod_q  <= 64'd0;
      rem_q   <= 32'd0;
      quot_q  <= 32'd0;
      dvs_q   <= 32'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall while starting or iterating; done is purely the DONE state.
  always_comb begin
    busy_o = start || (state_q == StMul) || (state_q == StDiv);
    done_o = (state_q == StDone);
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the driver pushes model results, a
// monitor pops and compares on each rising done_o.
module tb_muldiv_ctrl;

  localparam int unsigned MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        ready_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_total = 0;
  int n_pass  = 0;
  logic [63:0] exp_q[$];

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = ua * ub;
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return res;
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return MUL_LAT + 1;
    if (b == 32'd0) return 1;
    return 33;
  endfunction

  // Issue one op at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    int cyc;
    int busy_cnt;
    int lat;
    logic [31:0] h, l;
    lat = latency(op, b);
    exp_q.push_back(model(op, a, b));
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    ready_i = (hold == 0);
    cyc      = 0;
    busy_cnt = 0;
    @(negedge clk);
    while (!done_o && cyc < 200) begin
      if (busy_o) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 64'(cyc), 64'(lat));
    check("busy_cycles", 64'(busy_cnt), 64'(lat));
    check("busy_in_done", 64'(busy_o), 64'd0);
    valid_i = 1'b0;
    h = hi_o;
    l = lo_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_done", 64'(done_o), 64'd1);
      check("hold_busy", 64'(busy_o), 64'd0);
      check("hold_result", {hi_o, lo_o}, {h, l});
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_ready", 64'(done_o), 64'd0);
  endtask

  // Monitor: compare each new completion against the scoreboard.
  initial begin
    logic prev_done;
    logic [63:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) prev_done = 1'b0;
      else begin
        if (done_o && !prev_done) begin
          if (exp_q.size() == 0) check("spurious_done", 64'(done_o), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("result_hi", 64'(hi_o), 64'(e[63:32]));
            check("result_lo", 64'(lo_o), 64'(e[31:0]));
          end
        end
        prev_done = done_o;
      end
    end
  end

  initial begin
    logic [31:0] h, l, ra, rb;
    logic [1:0]  rop;
    int          seen;
    reset   = 1'b1;
    valid_i = 1'b0;
    op_i    = 2'b00;
    a_i     = 32'd0;
    b_i     = 32'd0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    #1;
    check("reset_outputs", {28'd0, busy_o, done_o, 2'b00, hi_o, lo_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0);
    do_op(2'b11, 32'd100, 32'd7, 0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b11, 32'h1234_5678, 32'd0, 0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1);

    // Flush a divide at cycle 10.
    h = hi_o;
    l = lo_o;
    valid_i = 1'b1;
    op_i    = 2'b10;
    a_i     = 32'd1000;
    b_i     = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) seen++;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_result", {hi_o, lo_o}, {h, l});
    @(posedge clk);
    #1;
    do_op(2'b01, 32'd6, 32'd7, 0);

    do_op(2'b11, 32'hDEAD_BEEF, 32'd13, 3);

    // Reset during multiply cycle 2.
    valid_i = 1'b1;
    op_i    = 2'b00;
    a_i     = 32'd9;
    b_i     = 32'd9;
    repeat (2) @(posedge clk);
    #1;
    valid_i = 1'b0;
    reset   = 1'b1;
    #1;
    check("midop_reset", {28'd0, busy_o, done_o, 2'b00, hi_o, lo_o}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_op(2'b00, 32'd2, 32'd3, 0);

    // Randomized ops with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op(rop, ra, rb, int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
